xor_descrambler_32bits: RTL and testbench
=========================================

// Module: xor_descrambler_32bits
// PURPOSE
//  Receive side of the XOR keystream masking path. Masked 32-bit words arrive on a
//  valid/ready stream. Each word is XORed with a keystream from a 32-bit Galois LFSR
//  that matches the transmitter's LFSR. The recovered word is returned on a
//  registered valid/ready output stream.
//  The block sits between the masked-data source and the datapath consumer. The
//  transmitter and this block stay in step by word count only.
// PARAMETERS
//  POLY   32'h04C11DB7  Galois LFSR feedback polynomial; must match the transmitter
//  SEED   32'hFFFFFFFF  keystream value after reset and on a zero seed load; must be nonzero
// PORTS
//  clk         in   1   rising-edge clock
//  reset_n     in   1   asynchronous, active-low reset
//  seed_load   in   1   load seed_in into the keystream register; restarts the stream
//  seed_in     in   32  new keystream value; 0 is replaced by SEED
//  in_valid    in   1   in_data holds a masked word
//  in_ready    out  1   block accepts in_data this cycle
//  in_data     in   32  masked word
//  out_valid   out  1   out_data holds a recovered word
//  out_ready   in   1   consumer accepts out_data this cycle
//  out_data    out  32  recovered word = masked word XOR the key in use when it was accepted
//  word_count  out  16  words accepted since reset or the last seed_load
// BEHAVIOUR
//  Reset (reset_n=0, any time, async): key=SEED, out_valid=0, out_data=0, word_count=0,
//   FSM=RUN. A word held in the output register is discarded.
//  FSM states:
//   RUN  - normal operation.
//   LOAD - one cycle, entered on seed_load. In LOAD: in_ready=0.
//          LOAD always returns to RUN on the next cycle.
//   The output register keeps draining in both states.
//  Keystream register:
//   - LOAD: key <= (seed_in==0) ? SEED : seed_in (seed_in sampled on the seed_load cycle);
//     word_count <= 0.
//   - Otherwise, on an input accept: key <= {key[30:0],1'b0} ^ (key[31] ? POLY : 32'h0).
//   - With any nonzero key the LFSR never reaches 0.
//  Handshake:
//   in_ready = (FSM==RUN) && !seed_load && (!out_valid || out_ready).
//   An input accept is a cycle with in_valid && in_ready. On accept:
//   out_data <= in_data ^ key; out_valid <= 1; word_count <= word_count+1.
//   word_count wraps from 16'hFFFF to 16'h0000.
//  Latency is 1 cycle from accept to out_valid. Throughput is 1 word/clk while out_ready=1.
//  If out_valid && !out_ready: out_data is held stable, in_ready=0, and key does not advance.
//  If out_valid && out_ready and no accept in the same cycle: out_valid <= 0 and
//   out_data keeps its last value.
//  Output accept and input accept in the same cycle: the new word replaces the old word
//   with no bubble.
//  seed_load arrives while a word is held: the held word is still delivered, and it
//   keeps the old-key result.
//  seed_load is asserted again while in LOAD: the FSM stays in LOAD and reloads.
// TESTING
//  1 Reset, out_ready=1: in_data=FFFFFFFF -> out_data=00000000 one cycle later.
//    Next in_data=00000000 -> out_data=FB3EE249. word_count=2.
//  2 Hold out_ready=0 after the first word -> in_ready=0 and out_data stays stable for 5 cycles.
//    Then release -> the next word uses key FB3EE249; no word is lost or duplicated.
//  3 seed_load with seed_in=00000000 -> key=FFFFFFFF and word_count=0.
//    in_ready=0 in the seed cycle and the LOAD cycle.
//    seed_in=12345678, then in_data=12345678 -> out_data=00000000.
//  4 Stream 1000 random words through a matching model scrambler -> all outputs equal
//    the originals, in order. Random in_valid/out_ready gaps.
//  5 Pulse reset_n low mid-stream while out_valid=1 -> out_valid=0 immediately
//    (asynchronous reset). After release, key=FFFFFFFF and word_count=0.
//  6 Force word_count to FFFF, accept one word -> word_count=0000.

Source files
------------

// File: rtl/xor_descrambler_32bits.sv
// Receive-side XOR keystream descrambler: masked words are XORed with a 32-bit Galois LFSR
// keystream that advances once per accepted word, and returned on a registered stream.
module xor_descrambler_32bits #(
    parameter logic [31:0] POLY = 32'h04C11DB7,
    parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] word_count
);

    typedef enum logic [0:0] {StRun, StLoad} state_e;

    state_e      state_q;
    logic [31:0] key_q;
    logic [15:0] count_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;

    logic [31:0] key_step;
    logic [31:0] seed_val;
    logic        in_accept;

    always_comb begin
        key_step  = {key_q[30:0], 1'b0} ^ (key_q[31] ? POLY : 32'h0);
        seed_val  = (seed_in == 32'h0) ? SEED : seed_in;
        in_ready  = (state_q == StRun) && !seed_load && (!out_valid_q || out_ready);
        in_accept = in_valid && in_ready;
    end

    // A seed load takes priority in either state; no accept can coincide with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            key_q   <= SEED;
            count_q <= 16'h0;
        end else begin
            case (state_q)
                StRun: begin
                    if (seed_load) begin
                        state_q <= StLoad;
                        key_q   <= seed_val;
                        count_q <= 16'h0;
                    end else if (in_accept) begin
                        key_q   <= key_step;
                        count_q <= count_q + 16'd1;
                    end
                end
                StLoad: begin
                    if (seed_load) begin
                        key_q   <= seed_val;
                        count_q <= 16'h0;
                    end else begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Output register drains independently of the FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
        end else if (in_accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data ^ key_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_xor_descrambler_32bits.sv
// Self-checking bench for xor_descrambler_32bits: directed cases plus a randomized
// scrambler/descrambler loopback against a queue-based reference model.
module tb_xor_descrambler_32bits;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_key;
    logic [15:0] m_count;
    logic        m_load;
    logic [31:0] m_last;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    xor_descrambler_32bits #(
        .POLY(POLY),
        .SEED(SEED)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_count(word_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Multiply by x modulo the polynomial in GF(2)[x].
    function automatic logic [31:0] gf_mulx(input logic [31:0] k);
        logic [32:0] w;
        w = {k, 1'b0};
        if (w[32]) w = w ^ {1'b1, POLY};
        return w[31:0];
    endfunction

    function automatic logic [31:0] seed_of(input logic [31:0] s);
        return (s == 32'h0) ? SEED : s;
    endfunction

    task automatic model_reset();
        m_key   = SEED;
        m_count = 16'h0;
        m_load  = 1'b0;
        m_last  = 32'h0;
        exp_q.delete();
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic sl, input logic [31:0] si,
                         output logic ia, output logic oa, output logic [31:0] od);
        logic exp_ready;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        seed_load = sl;
        seed_in   = si;
        #1;
        exp_ready = !sl && !m_load && ((exp_q.size() == 0) || ordy);
        check_eq("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
        check_eq("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : m_last);
        check_eq("word_count", {16'h0, word_count}, {16'h0, m_count});
        check_eq("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
        od = out_data;
        oa = (exp_q.size() != 0) && ordy;
        if (oa) m_last = exp_q.pop_front();
        ia = iv && exp_ready;
        if (ia) begin
            exp_q.push_back(id ^ m_key);
            m_key   = gf_mulx(m_key);
            m_count = m_count + 16'd1;
        end
        if (sl) begin
            m_key   = seed_of(si);
            m_count = 16'h0;
        end
        m_load = sl;
    endtask

    task automatic step(input logic iv, input logic [31:0] id, input logic ordy);
        logic ia, oa;
        logic [31:0] od;
        cycle(iv, id, ordy, 1'b0, 32'h0, ia, oa, od);
    endtask

    task automatic seed_step(input logic iv, input logic [31:0] si);
        logic ia, oa;
        logic [31:0] od;
        cycle(iv, 32'h0, 1'b1, 1'b1, si, ia, oa, od);
    endtask

    task automatic do_reset();
        #2;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        reset_n   = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_out_data", out_data, 32'h0);
        check_eq("rst_word_count", {16'h0, word_count}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic        ia, oa, iv, ordy, sl;
        logic [31:0] od, si, orig, tx_key;
        logic [31:0] orig_q[$];
        int          n_in, n_out, cyc;

        // 1: basic keystream
        do_reset();
        step(1'b1, 32'hFFFFFFFF, 1'b1);
        step(1'b1, 32'h00000000, 1'b1);
        check_eq("t1_first", out_data, 32'h00000000);
        step(1'b0, 32'h0, 1'b1);
        check_eq("t1_second", out_data, 32'hFB3EE249);
        check_eq("t1_count", {16'h0, word_count}, 32'd2);

        // 2: backpressure hold
        do_reset();
        step(1'b1, 32'hFFFFFFFF, 1'b1);
        repeat (5) step(1'b1, 32'h0, 1'b0);
        check_eq("t2_held", out_data, 32'h00000000);
        check_eq("t2_ready", {31'h0, in_ready}, 32'h0);
        step(1'b1, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("t2_next", out_data, 32'hFB3EE249);
        check_eq("t2_count", {16'h0, word_count}, 32'd2);
        step(1'b0, 32'h0, 1'b1);

        // 3: seed loads
        seed_step(1'b1, 32'h0);
        step(1'b1, 32'h0, 1'b1);
        check_eq("t3_load_count", {16'h0, word_count}, 32'h0);
        step(1'b1, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("t3_zero_seed", out_data, 32'hFFFFFFFF);
        seed_step(1'b0, 32'h12345678);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h12345678, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("t3_seed", out_data, 32'h00000000);

        // 4: randomized loopback through a model scrambler
        do_reset();
        tx_key = SEED;
        orig   = $urandom;
        n_in   = 0;
        n_out  = 0;
        cyc    = 0;
        while (n_in < 1000 && cyc < 20000) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            sl   = ($urandom_range(0, 49) == 0);
            si   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            cycle(iv, orig ^ tx_key, ordy, sl, si, ia, oa, od);
            if (oa) begin
                if (orig_q.size() != 0) check_eq("rand_data", od, orig_q.pop_front());
                n_out++;
            end
            if (ia) begin
                orig_q.push_back(orig);
                tx_key = gf_mulx(tx_key);
                orig   = $urandom;
                n_in++;
            end
            if (sl) tx_key = seed_of(si);
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, ia, oa, od);
            if (oa) begin
                if (orig_q.size() != 0) check_eq("rand_data", od, orig_q.pop_front());
                n_out++;
            end
        end
        check_eq("rand_in", n_in, 32'd1000);
        check_eq("rand_out", n_out, 32'd1000);

        // 5: asynchronous reset while a word is held
        step(1'b1, 32'hA5A5A5A5, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        check_eq("t5_pre_valid", {31'h0, out_valid}, 32'h1);
        do_reset();
        step(1'b1, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("t5_key", out_data, 32'hFFFFFFFF);
        check_eq("t5_count", {16'h0, word_count}, 32'd1);

        // 6: word_count wrap
        do_reset();
        for (int i = 0; i < 65535; i++) step(1'b1, i, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("t6_ffff", {16'h0, word_count}, 32'h0000FFFF);
        step(1'b1, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("t6_wrap", {16'h0, word_count}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
